// File: rtl/led_pkg.sv
// Shared constants and digit-rotation helper for the seven-segment scan controller.
package led_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned DIGIT_W    = 3;
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 8'hFF;

  // First enabled digit after sel (wrapping); falls back to sel when nothing else is enabled.
  function automatic logic [DIGIT_W-1:0] next_enabled(input logic [DIGIT_W-1:0]    sel,
                                                      input logic [NUM_DIGITS-1:0] mask);
    logic [DIGIT_W-1:0] nxt;
    logic [DIGIT_W-1:0] cand;
    logic               found;
    nxt   = sel;
    found = 1'b0;
    for (int unsigned i = 1; i <= NUM_DIGITS; i++) begin
      cand = sel + DIGIT_W'(i);
      if (!found && mask[cand]) begin
        nxt   = cand;
        found = 1'b1;
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Digit-slot prescaler: counts 0..TICK_DIV-1 while enabled, parked at 0 otherwise.
module tick_gen #(
  parameter int unsigned TICK_DIV = 100000,
  localparam int unsigned CNT_W   = $clog2(TICK_DIV)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  // Terminal-count strobe is combinational so the slot advance lands on the wrap edge.
  assign tc = en && (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (!en || tc) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_scan_controller.sv
// Time-multiplexed 8-digit scan: digit select, active-low anodes with blanking, slot tick.
module led_scan_controller
  import led_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic [NUM_DIGITS-1:0] digit_mask,
  output logic [DIGIT_W-1:0]    sel,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  slot_tick
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);

  logic [CNT_W-1:0]      cnt;
  logic                  tc;
  int unsigned           cnt_nxt;
  logic [DIGIT_W-1:0]    sel_nxt;
  logic [NUM_DIGITS-1:0] an_nxt;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .cnt     (cnt),
    .tc      (tc)
  );

  // Anodes are decoded from the post-edge counter and select so sel and an switch together.
  always_comb begin
    sel_nxt = sel;
    cnt_nxt = 32'(cnt) + 32'd1;
    an_nxt  = ANODE_OFF;
    if (!en || tc) begin
      cnt_nxt = 32'd0;
    end
    if (tc) begin
      sel_nxt = next_enabled(sel, digit_mask);
    end
    if (en && (cnt_nxt >= BLANK_CYCLES) && digit_mask[sel_nxt]) begin
      an_nxt = ~(NUM_DIGITS'(1) << sel_nxt);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel       <= '0;
      an        <= ANODE_OFF;
      slot_tick <= 1'b0;
    end else begin
      sel       <= sel_nxt;
      an        <= an_nxt;
      slot_tick <= tc;
    end
  end

endmodule

// File: tb/tb_led_scan_controller.sv
// Directed bench for led_scan_controller with TICK_DIV=4, BLANK_CYCLES=1.
module tb_led_scan_controller;

  localparam int unsigned TD = 4;
  localparam int unsigned BC = 1;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en;
  logic [7:0] digit_mask;
  logic [2:0] sel;
  logic [7:0] an;
  logic       slot_tick;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] mask;
    logic [2:0] sel;
    logic [7:0] an;
    logic       tick;
    string      name;
  } vec_t;

  vec_t vecs[$];
  int   sq[$];

  always #5 clk = ~clk;

  led_scan_controller #(
    .TICK_DIV     (TD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (en),
    .digit_mask (digit_mask),
    .sel        (sel),
    .an         (an),
    .slot_tick  (slot_tick)
  );

  function automatic logic [7:0] lit(input logic [2:0] s);
    logic [7:0] one;
    one = 8'h01;
    return ~(one << s);
  endfunction

  task automatic chk(input string name, input logic [2:0] es, input logic [7:0] ea, input logic et);
    total++;
    if (sel !== es || an !== ea || slot_tick !== et) begin
      bad++;
      $display("FAIL %s @%0t: got sel=%0d an=%h tick=%b, want sel=%0d an=%h tick=%b",
               name, $time, sel, an, slot_tick, es, ea, et);
    end
  endtask

  task automatic do_reset(input logic e, input logic [7:0] m);
    @(negedge clk);
    reset_n    = 1'b0;
    en         = 1'($urandom);
    digit_mask = 8'($urandom);
    repeat (2) @(posedge clk);
    #1 chk("reset_hold", 3'd0, 8'hFF, 1'b0);
    @(negedge clk);
    en         = e;
    digit_mask = m;
    reset_n    = 1'b1;
  endtask

  task automatic step(input logic e, input logic [7:0] m);
    en         = e;
    digit_mask = m;
    @(posedge clk);
    #1;
  endtask

  // Builds one scenario from reset: sq lists the digit shown in each 4-cycle slot.
  task automatic add_seq(input string nm, input logic [7:0] m);
    vec_t       v;
    logic [2:0] s;
    for (int k = 1; k <= 4 * sq.size() - 1; k++) begin
      s      = 3'(sq[k / 4]);
      v.rst  = (k == 1);
      v.en   = 1'b1;
      v.mask = m;
      v.sel  = s;
      v.tick = ((k % 4) == 0);
      v.an   = (((k % 4) == 0) || !m[s]) ? 8'hFF : lit(s);
      v.name = nm;
      vecs.push_back(v);
    end
  endtask

  // At most one anode may ever be low.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      total++;
      if ($countones(~an) > 1) begin
        bad++;
        $display("FAIL onehot_low @%0t: got an=%h, want at most one zero bit", $time, an);
      end
    end
  end

  initial begin
    reset_n    = 1'b0;
    en         = 1'b0;
    digit_mask = 8'h00;

    sq = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
    add_seq("full_scan", 8'hFF);
    sq = '{0, 2, 7, 0, 2, 7, 0, 2, 7};
    add_seq("skip_85", 8'h85);
    sq = '{0, 0, 0, 0};
    add_seq("all_masked", 8'h00);
    sq = '{0, 3, 3, 3, 3};
    add_seq("single_08", 8'h08);

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset(vecs[i].en, vecs[i].mask);
      step(vecs[i].en, vecs[i].mask);
      chk(vecs[i].name, vecs[i].sel, vecs[i].an, vecs[i].tick);
    end

    // Asynchronous reset mid-slot, checked between clock edges.
    do_reset(1'b1, 8'hFF);
    repeat (6) step(1'b1, 8'hFF);
    chk("pre_async", 3'd1, 8'hFD, 1'b0);
    #2 reset_n = 1'b0;
    #1 chk("async_reset", 3'd0, 8'hFF, 1'b0);

    // Enable dropped mid-slot, then restored.
    do_reset(1'b1, 8'hFF);
    repeat (5) step(1'b1, 8'hFF);
    chk("gate_pre", 3'd1, 8'hFD, 1'b0);
    step(1'b0, 8'hFF);
    chk("gate_drop", 3'd1, 8'hFF, 1'b0);
    repeat (3) begin
      step(1'b0, 8'hFF);
      chk("gate_hold", 3'd1, 8'hFF, 1'b0);
    end
    step(1'b1, 8'hFF);
    chk("gate_rise", 3'd1, 8'hFD, 1'b0);
    repeat (2) begin
      step(1'b1, 8'hFF);
      chk("gate_lit", 3'd1, 8'hFD, 1'b0);
    end
    step(1'b1, 8'hFF);
    chk("gate_adv", 3'd2, 8'hFF, 1'b1);
    step(1'b1, 8'hFF);
    chk("gate_next", 3'd2, 8'hFB, 1'b0);

    // Current digit masked while lit.
    do_reset(1'b1, 8'hFF);
    step(1'b1, 8'hFF);
    chk("mask_pre", 3'd0, 8'hFE, 1'b0);
    step(1'b1, 8'hFE);
    chk("mask_clr", 3'd0, 8'hFF, 1'b0);
    step(1'b1, 8'hFE);
    chk("mask_wait", 3'd0, 8'hFF, 1'b0);
    step(1'b1, 8'hFE);
    chk("mask_adv", 3'd1, 8'hFF, 1'b1);
    step(1'b1, 8'hFE);
    chk("mask_next", 3'd1, 8'hFD, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_scan_controller.md
Name: led_scan_controller

Overview:
- Time-multiplexed scan controller for the 8-digit seven-segment display.
- Generates the 3-bit digit select that drives the 8-to-1 nibble mux feeding the hex-to-7-segment decoder.
- Generates the matching active-low anode enables for the same digit.
- Supports a per-digit enable mask and an anti-ghosting blanking interval at the start of each digit slot.

Parameters:
- TICK_DIV, 100000, clk cycles per digit slot; legal range >= 2.
- BLANK_CYCLES, 1000, cycles at the start of each slot with all anodes off; must be < TICK_DIV; 0 disables blanking.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- en  input  1  scan enable; 0 freezes the scan and blanks the display.
- digit_mask  input  8  bit i = 1 means digit i is shown; masked digits are skipped.
- sel  output  3  current digit index, to the mux select.
- an  output  8  anode enables, active-low, one-hot-low when lit.
- slot_tick  output  1  one-cycle pulse on each slot advance.

Behaviour:
- Reset (async assert, sync release): cnt = 0, sel = 3'd0, an = 8'hFF, slot_tick = 0.
- cnt is the prescaler, width $clog2(TICK_DIV).
- All outputs are registered. an is computed from post-edge cnt/sel, so sel and an change on the same edge with zero skew.
- en = 1 and cnt < TICK_DIV-1: cnt increments; sel holds; slot_tick = 0.
- en = 1 and cnt == TICK_DIV-1, same edge:
  - cnt <= 0.
  - sel <= next_enabled(sel).
  - slot_tick <= 1 for exactly one cycle.
- next_enabled(s): first index j in s+1, s+2, ... wrapping 7 -> 0, checked over 8 candidates, with digit_mask[j] = 1.
  - If only s is enabled, it returns s. slot_tick still pulses.
  - If digit_mask == 0, it returns s (sel holds).
- an value:
  - 8'hFF if en == 0, or cnt < BLANK_CYCLES, or digit_mask[sel] == 0.
  - Otherwise ~(8'b1 << sel).
- en = 0:
  - cnt is held at 0 and sel holds its value.
  - slot_tick = 0 and an = 8'hFF from the first edge after en falls.
  - When en rises, a full slot (starting with blanking) begins on that edge.
- digit_mask changing mid-slot:
  - If the current sel becomes masked, an goes 8'hFF on the next edge.
  - sel still advances only at the terminal count; no early skip.
- Reset asserted mid-slot: outputs go to reset values immediately, without waiting for a clock edge.
- Never more than one anode low. No anode low during blanking.
- Full refresh period = TICK_DIV x (number of enabled digits).

Decomposition:
- Shared package led_pkg:
  - NUM_DIGITS = 8.
  - DIGIT_W = 3.
  - ANODE_OFF = 8'hFF.
  - function next_enabled(sel, mask).
- One natural sub-module: tick_gen, the prescaler.
  - Ports: clk, reset_n, en, cnt, tc (terminal-count strobe).
  - Parameterised by TICK_DIV.
- Remaining logic (sel register, anode decode, blanking compare) stays in the top level.

Test Plan:
- Reset: hold reset_n = 0 with random inputs -> sel = 0, an = 8'hFF, slot_tick = 0. Assert reset_n asynchronously mid-slot -> outputs reset with no clock edge.
- Full scan, TICK_DIV = 4, BLANK_CYCLES = 1, mask = 8'hFF, en = 1 -> sel steps 0,1,...,7,0 every 4 cycles.
  - an = FF for 1 cycle, then ~(1 << sel) for 3 cycles, in every slot.
  - slot_tick pulses once per 4 cycles, coincident with the sel change.
- Skip: mask = 8'b1000_0101 -> sel sequence 0,2,7,0,2,...; an for digit 7 = 8'h7F; period 12 cycles.
- All masked: mask = 0 -> sel frozen; an = FF throughout; slot_tick still pulses every 4 cycles.
- Enable gating: drop en mid-slot -> an = FF and cnt = 0 on the next edge; sel unchanged. Raise en -> blanking cycle, then the same digit lights for the remaining 3 cycles of that slot.
- Mid-slot mask change: clear digit_mask[sel] while that digit is lit -> an = FF on the next edge; sel advances only at the terminal count.
- Invariant assertions: at most one zero bit in an; an = FF whenever cnt < BLANK_CYCLES.
